// File: rtl/slt_32bit_core.sv
// Signed set-on-less-than for the MiniMIPS ALU (SLT/SLTI).
// The comparison uses a ripple subtractor with overflow correction. The result is registered with one-cycle latency.
module slt_32bit_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             out_valid,
  output logic [WIDTH-1:0] slt
);

  logic [WIDTH-1:0] value2_inv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] carry;
  logic             ovf_c;
  logic             less_c;

  assign value2_inv = ~value2;
  assign carry[0]   = 1'b1;

  // value1 + ~value2 + 1 as a chain of full adders; the final carry-out is not needed
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i] = value1[i] ^ value2_inv[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (value1[i] & value2_inv[i]) |
                          (carry[i] & (value1[i] ^ value2_inv[i]));
    end
  end

  // Sign of the difference, corrected when operands of opposite sign overflow
  assign ovf_c  = (value1[WIDTH-1] ^ value2[WIDTH-1]) & (value1[WIDTH-1] ^ diff[WIDTH-1]);
  assign less_c = diff[WIDTH-1] ^ ovf_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slt       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      slt       <= {{(WIDTH-1){1'b0}}, less_c};
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slt_32bit_core.sv
// Bench for slt_32bit_core. Directed vectors queue their expected results.
// A monitor compares each expected result against the DUT output in the cycle that output is due.
module tb_slt_32bit_core;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] value1;
  logic [31:0] value2;
  logic        out_valid;
  logic [31:0] slt;

  typedef struct {
    int          due;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  slt_32bit_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .value1    (value1),
    .value2    (value2),
    .out_valid (out_valid),
    .slt       (slt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // The driver sets inputs on the falling edge; the DUT captures them at the next rising edge.
  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] req);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    value1   = a;
    value2   = b;
    e.due    = cyc + 1;
    e.val    = req;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // The monitor pops and compares the expected result whenever out_valid is high.
  // It also flags a result that is missing or arrives early.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cycle=%0d actual_slt=%08h required=no_output", cyc, slt);
      end else begin
        exp_t e;
        e = q.pop_front();
        check(e.name, slt, e.val);
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_%s cycle=%0d actual_valid=%b required_valid=1", e.name, cyc, out_valid);
    end
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    value1   = '0;
    value2   = '0;

    // Reset is held for two cycles, then released with no input.
    repeat (2) @(negedge clk);
    check("reset_slt", slt, 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_slt_zero", slt, 32'h0);
    check("idle_valid_zero", 32'(out_valid), 32'h0);

    // Small positive operands
    send("sp_fff0_ffff", 32'h000FFFF0, 32'h000FFFFF, 32'h1);
    idle();
    send("sp_1_2", 32'h00000001, 32'h00000002, 32'h1);
    idle();
    send("sp_2_1", 32'h00000002, 32'h00000001, 32'h0);
    idle();

    // Large positive operands and a negative operand
    send("lp_4000_3fff", 32'h40000000, 32'h3FFFFFFF, 32'h0);
    idle();
    send("neg_fff0_0", 32'hFFF00000, 32'h00000000, 32'h1);
    idle();
    @(negedge clk);
    check("hold_slt", slt, 32'h1);
    check("hold_valid", 32'(out_valid), 32'h0);

    // Overflow corners and equal operands
    send("ovf_min_max", 32'h80000000, 32'h7FFFFFFF, 32'h1);
    idle();
    send("ovf_max_min", 32'h7FFFFFFF, 32'h80000000, 32'h0);
    idle();
    send("eq_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    idle();

    // Back-to-back pairs with in_valid held high for five cycles
    send("b2b_5_m3", 32'h00000005, 32'hFFFFFFFD, 32'h0);
    send("b2b_m3_5", 32'hFFFFFFFD, 32'h00000005, 32'h1);
    send("b2b_0_m1", 32'h00000000, 32'hFFFFFFFF, 32'h0);
    send("b2b_m2_m1", 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1);
    send("b2b_min_min", 32'h80000000, 32'h80000000, 32'h0);
    idle();
    check("b2b_last_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    check("b2b_drop_valid", 32'(out_valid), 32'h0);

    // Reset asserted in the same cycle as a valid input must win.
    send("pre_rst_1_2", 32'h00000001, 32'h00000002, 32'h1);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    value1   = 32'h00000001;
    value2   = 32'h00000002;
    @(negedge clk);
    check("rst_wins_slt", slt, 32'h0);
    check("rst_wins_valid", 32'(out_valid), 32'h0);
    reset_n  = 1'b1;
    in_valid = 1'b0;

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual_pending=%0d required_pending=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
